uart_tx_fifo_sequencer: RTL and testbench

UART_TX_FIFO_SEQUENCER -- requirements
Module: uart_tx_fifo_sequencer

---
 rtl/uart_tx_fifo_sequencer_pkg.sv | 16 +
 rtl/uart_tx_fifo_sequencer_if.sv | 26 ++
 rtl/uart_fifo_lat_timer.sv | 27 ++
 rtl/uart_tx_fifo_sequencer.sv | 122 ++++++++++++
 tb/tb_uart_tx_fifo_sequencer.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_fifo_sequencer_pkg.sv
// Shared definitions for the UART transmit FIFO sequencer: state encoding
// and the default byte-path width and FIFO read latency.
package uart_tx_fifo_sequencer_pkg;

  localparam int RD_LATENCY_DEF = 2;
  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    PRESENT = 3'd3,
    DRAIN   = 3'd4
  } state_t;

endpackage

// File: rtl/uart_tx_fifo_sequencer_if.sv
// FIFO read port and transmitter handshake bundled as one bus; master is the
// sequencer side, slave is the FIFO/transmitter side.
interface uart_tx_fifo_sequencer_if
  import uart_tx_fifo_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_rd_n;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (
    input  fifo_empty, fifo_data, tx_ready,
    output fifo_rd_n, tx_data, tx_valid
  );

  modport slave (
    output fifo_empty, fifo_data, tx_ready,
    input  fifo_rd_n, tx_data, tx_valid
  );

endinterface

// File: rtl/uart_fifo_lat_timer.sv
// Loadable 2-bit down-counter that times the FIFO read latency; done marks
// the last cycle before read data is valid to capture.
module uart_fifo_lat_timer (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load,
  input  logic [1:0] load_value,
  output logic       done
);

  logic [1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= 2'd0;
    end else if (load) begin
      count <= load_value;
    end else if (count != 2'd0) begin
      count <= count - 2'd1;
    end
  end

  assign done = (count == 2'd1);

endmodule

// File: rtl/uart_tx_fifo_sequencer.sv
// Pops bytes from a fixed-latency FIFO and offers them to a UART transmitter
// over a valid/ready handshake, with flush-and-drain support.
module uart_tx_fifo_sequencer
  import uart_tx_fifo_sequencer_pkg::*;
#(
  parameter int RD_LATENCY = RD_LATENCY_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic                        flush,
  output logic                        busy,
  output logic                        flush_done,
  output logic [7:0]                  sent_count,
  uart_tx_fifo_sequencer_if.master    bus
);

  state_t                state;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  flush_pend;
  logic                  armed;
  logic                  lat_done;
  logic                  handshake;
  logic                  drain_exit;

  uart_fifo_lat_timer u_lat_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (state == ISSUE),
    .load_value (2'(RD_LATENCY)),
    .done       (lat_done)
  );

  assign handshake  = (state == PRESENT) && bus.tx_ready;
  assign drain_exit = (state == DRAIN) && bus.fifo_empty;
  assign bus.tx_data = tx_data_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next     = state;
    bus.fifo_rd_n  = 1'b1;
    bus.tx_valid   = 1'b0;
    busy           = (state != IDLE);
    flush_done     = 1'b0;

    case (state)
      IDLE: begin
        // armed holds off any FIFO activity until the second edge after reset
        if (armed) begin
          if (flush || flush_pend) begin
            state_next = DRAIN;
          end else if (enable && !bus.fifo_empty) begin
            state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        bus.fifo_rd_n = bus.fifo_empty;
        state_next    = WAIT;
      end
      WAIT: begin
        if (lat_done) begin
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        bus.tx_valid = 1'b1;
        if (handshake) begin
          if (flush_pend || flush) begin
            state_next = DRAIN;
          end else if (enable && !bus.fifo_empty) begin
            state_next = ISSUE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DRAIN: begin
        bus.fifo_rd_n = bus.fifo_empty;
        flush_done    = bus.fifo_empty;
        if (bus.fifo_empty) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_data_q  <= '0;
      sent_count <= 8'd0;
      flush_pend <= 1'b0;
      armed      <= 1'b0;
    end else begin
      armed <= 1'b1;
      if ((state == WAIT) && lat_done) begin
        tx_data_q <= bus.fifo_data;
      end
      if (handshake) begin
        sent_count <= sent_count + 8'd1;
      end
      if (drain_exit) begin
        flush_pend <= 1'b0;
      end else if (flush && (state != IDLE)) begin
        flush_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_sequencer.sv
// Directed bench for uart_tx_fifo_sequencer with a latency-2 FIFO model and a
// handshake monitor; expected values are hand-computed per scenario.
module tb_uart_tx_fifo_sequencer;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable  = 1'b0;
  logic       flush   = 1'b0;
  logic       busy;
  logic       flush_done;
  logic [7:0] sent_count;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_fifo_sequencer_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_fifo_sequencer #(
    .RD_LATENCY (2),
    .DATA_WIDTH (8)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .flush      (flush),
    .busy       (busy),
    .flush_done (flush_done),
    .sent_count (sent_count),
    .bus        (bus)
  );

  always #5 clock = ~clock;

  // FIFO model: one pop per low fifo_rd_n cycle, data valid two cycles later
  logic [7:0] mem [0:511];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic [7:0] d1 = 8'h00;
  logic [7:0] d2 = 8'h00;

  assign bus.fifo_empty = (rd_ptr == wr_ptr);
  assign bus.fifo_data  = d2;

  always @(posedge clock) begin
    if (!bus.fifo_rd_n && (rd_ptr != wr_ptr)) begin
      rd_ptr <= rd_ptr + 1;
      d1     <= mem[rd_ptr % 512];
    end else begin
      d1 <= 8'hEE;
    end
    d2 <= d1;
  end

  // Monitor: pops, underflows, accepted bytes, valid dropped without handshake
  int         pops = 0;
  int         underflows = 0;
  int         drops = 0;
  int         rx_n = 0;
  logic [7:0] rx_log [0:1023];
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic       prev_rst   = 1'b0;

  always @(negedge clock) begin
    if (reset_n) begin
      if (!bus.fifo_rd_n) pops++;
      if (!bus.fifo_rd_n && bus.fifo_empty) underflows++;
      if (bus.tx_valid && bus.tx_ready) begin
        rx_log[rx_n % 1024] = bus.tx_data;
        rx_n++;
      end
      if (prev_rst && prev_valid && !prev_ready && !bus.tx_valid) drops++;
    end
    prev_valid = bus.tx_valid;
    prev_ready = bus.tx_ready;
    prev_rst   = reset_n;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 512] = b;
    wr_ptr++;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit seen = 1'b0;
    tick();
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clock);
      if (!busy) seen = 1'b1;
    end
    check({tag, "_idle"}, 32'(seen), 32'd1);
    tick();
  endtask

  task automatic wait_valid(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clock);
      if (bus.tx_valid) seen = 1'b1;
    end
    check({tag, "_valid"}, 32'(seen), 32'd1);
  endtask

  // Records per-cycle masks starting at the current drive point (cycle 0)
  task automatic trace(input int n, input int flush_k,
                       output logic [15:0] rd_m, output logic [15:0] val_m,
                       output logic [15:0] done_m, output logic [7:0] first_data);
    bit got = 1'b0;
    rd_m = '0;
    val_m = '0;
    done_m = '0;
    first_data = '0;
    for (int k = 0; k < n; k++) begin
      if (k == flush_k) flush = 1'b1;
      else if (k == flush_k + 1) flush = 1'b0;
      @(negedge clock);
      rd_m[k]   = !bus.fifo_rd_n;
      val_m[k]  = bus.tx_valid;
      done_m[k] = flush_done;
      if (bus.tx_valid && !got) begin
        got = 1'b1;
        first_data = bus.tx_data;
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded its time bound");
    $fatal(1);
  end

  initial begin
    logic [15:0] rd_m, val_m, done_m;
    logic [7:0]  fd;
    int          p0, r0, u0, errs;

    bus.tx_ready = 1'b0;

    // Reset values
    repeat (2) @(negedge clock);
    check("rst_tx_valid",   32'(bus.tx_valid),  32'd0);
    check("rst_fifo_rd_n",  32'(bus.fifo_rd_n), 32'd1);
    check("rst_busy",       32'(busy),          32'd0);
    check("rst_flush_done", 32'(flush_done),    32'd0);
    check("rst_sent_count", 32'(sent_count),    32'd0);
    check("rst_tx_data",    32'(bus.tx_data),   32'd0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();

    // Single byte: pop in cycle 1, valid in cycle 4
    push(8'hA5);
    bus.tx_ready = 1'b1;
    enable = 1'b1;
    trace(8, -1, rd_m, val_m, done_m, fd);
    check("single_rd_mask",    32'(rd_m),  32'h0002);
    check("single_valid_mask", 32'(val_m), 32'h0010);
    check("single_data",       32'(fd),    32'hA5);
    check("single_sent",       32'(sent_count), 32'd1);
    check("single_empty",      32'(bus.fifo_empty), 32'd1);
    check("single_busy",       32'(busy), 32'd0);

    // Backpressure with enable dropped mid-transfer
    bus.tx_ready = 1'b0;
    push(8'h3C);
    push(8'h77);
    wait_valid("bp", 20);
    tick();
    enable = 1'b0;
    p0 = pops;
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h3C) errs++;
      tick();
    end
    check("bp_stable_errs", 32'(errs), 32'd0);
    check("bp_no_pop",      32'(pops - p0), 32'd0);
    bus.tx_ready = 1'b1;
    tick();
    repeat (3) tick();
    check("bp_sent",       32'(sent_count), 32'd2);
    check("bp_rx_byte",    32'(rx_log[(rx_n - 1) % 1024]), 32'h3C);
    check("bp_busy_hold",  32'(busy), 32'd0);
    check("bp_pop_hold",   32'(pops - p0), 32'd0);
    enable = 1'b1;
    wait_idle("bp2", 40);
    check("bp2_rx_byte", 32'(rx_log[(rx_n - 1) % 1024]), 32'h77);
    check("bp2_sent",    32'(sent_count), 32'd3);

    // Burst of five
    p0 = pops;
    r0 = rx_n;
    u0 = underflows;
    for (int i = 1; i <= 5; i++) push(8'(i));
    wait_idle("burst", 100);
    check("burst_pops",  32'(pops - p0), 32'd5);
    check("burst_count", 32'(rx_n - r0), 32'd5);
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      if (rx_log[(r0 + i) % 1024] !== 8'(i + 1)) errs++;
    end
    check("burst_data_errs", 32'(errs), 32'd0);
    check("burst_sent",      32'(sent_count), 32'd8);
    check("burst_underflow", 32'(underflows - u0), 32'd0);

    // Flush during WAIT of the first of four bytes
    p0 = pops;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    trace(12, 2, rd_m, val_m, done_m, fd);
    check("flush_rd_mask",    32'(rd_m),   32'h00E2);
    check("flush_valid_mask", 32'(val_m),  32'h0010);
    check("flush_done_mask",  32'(done_m), 32'h0100);
    check("flush_data",       32'(fd),     32'h11);
    check("flush_sent",       32'(sent_count), 32'd9);
    check("flush_pops",       32'(pops - p0), 32'd4);
    check("flush_busy",       32'(busy), 32'd0);

    // Flush from IDLE with enable low
    enable = 1'b0;
    push(8'h55);
    push(8'h66);
    trace(6, 0, rd_m, val_m, done_m, fd);
    check("idle_flush_rd_mask",   32'(rd_m),   32'h0006);
    check("idle_flush_done_mask", 32'(done_m), 32'h0008);
    check("idle_flush_valid",     32'(val_m),  32'h0000);
    check("idle_flush_sent",      32'(sent_count), 32'd9);

    // Reset while presenting, then resume
    enable = 1'b1;
    bus.tx_ready = 1'b0;
    push(8'h5A);
    push(8'h6B);
    wait_valid("rstp", 20);
    tick();
    reset_n = 1'b0;
    #1;
    check("rstp_tx_valid", 32'(bus.tx_valid),  32'd0);
    check("rstp_fifo_rd_n", 32'(bus.fifo_rd_n), 32'd1);
    check("rstp_sent",     32'(sent_count),    32'd0);
    check("rstp_busy",     32'(busy),          32'd0);
    check("rstp_tx_data",  32'(bus.tx_data),   32'd0);
    bus.tx_ready = 1'b1;
    tick();
    reset_n = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("rstp_edge1_rd_n", 32'(bus.fifo_rd_n), 32'd1);
    @(negedge clock);
    check("rstp_edge2_rd_n", 32'(bus.fifo_rd_n), 32'd0);
    wait_idle("rstp", 40);
    check("rstp_rx_byte", 32'(rx_log[(rx_n - 1) % 1024]), 32'h6B);
    check("rstp_resume_sent", 32'(sent_count), 32'd1);

    // Count wrap: 255 more bytes take sent_count from 1 through 255 to 0
    r0 = rx_n;
    for (int i = 0; i < 255; i++) push(8'(i));
    wait_idle("wrap", 1400);
    check("wrap_count", 32'(rx_n - r0), 32'd255);
    errs = 0;
    for (int i = 0; i < 255; i++) begin
      if (rx_log[(r0 + i) % 1024] !== 8'(i)) errs++;
    end
    check("wrap_data_errs", 32'(errs), 32'd0);
    check("wrap_sent",      32'(sent_count), 32'd0);

    check("total_underflows", 32'(underflows), 32'd0);
    check("total_drops",      32'(drops),      32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
